// File: rtl/branch_checkpoint_manager_if.sv
// Branch checkpoint manager bus.
// Groups the rename-side requests (alloc, delay-slot update), the resolve and
// restore inputs from misprediction recovery, and the checkpoint state
// presented back to rename and recovery.
//   slave  : the checkpoint manager (consumes requests, drives ckpt_* state)
//   master : rename / recovery side (drives requests, observes state)
interface branch_checkpoint_manager_if #(
    parameter int BRANCH_NUM             = 4,
    parameter int BRANCH_NUM_INDEX       = 2,
    parameter int REG_NUM                = 32,
    parameter int PHYS_REG_NUM_INDEX     = 6,
    parameter int ACTIVE_LIST_SIZE_INDEX = 5
);
    // rename-side allocation request
    logic                                                alloc_req;
    logic [ACTIVE_LIST_SIZE_INDEX-1:0]                   alloc_branch_id;
    logic [PHYS_REG_NUM_INDEX-1:0]                       alloc_free_head_pointer;
    logic [REG_NUM*PHYS_REG_NUM_INDEX-1:0]               alloc_rename_buffer;
    // delay-slot update of the most recent checkpoint
    logic                                                ds_req;
    logic [PHYS_REG_NUM_INDEX-1:0]                       ds_free_head_pointer;
    logic [REG_NUM*PHYS_REG_NUM_INDEX-1:0]               ds_rename_buffer;
    // correct-prediction resolution
    logic                                                resolve_valid;
    logic [ACTIVE_LIST_SIZE_INDEX-1:0]                   resolve_branch_id;
    // mispredict recovery
    logic                                                restore_en;
    logic [BRANCH_NUM-1:0]                               restore_valid;
    logic [BRANCH_NUM_INDEX-1:0]                         restore_write_pointer;
    // checkpoint state
    logic                                                full;
    logic [BRANCH_NUM_INDEX-1:0]                         alloc_idx;
    logic [BRANCH_NUM-1:0]                               ckpt_valid;
    logic [BRANCH_NUM_INDEX-1:0]                         ckpt_write_pointer;
    logic [BRANCH_NUM-1:0]                               ckpt_ds_valid;
    logic [BRANCH_NUM*ACTIVE_LIST_SIZE_INDEX-1:0]        ckpt_branch_id;
    logic [BRANCH_NUM*PHYS_REG_NUM_INDEX-1:0]            ckpt_free_head_pointer;
    logic [BRANCH_NUM*REG_NUM*PHYS_REG_NUM_INDEX-1:0]    ckpt_rename_buffer;

    modport slave (
        input  alloc_req, alloc_branch_id, alloc_free_head_pointer, alloc_rename_buffer,
        input  ds_req, ds_free_head_pointer, ds_rename_buffer,
        input  resolve_valid, resolve_branch_id,
        input  restore_en, restore_valid, restore_write_pointer,
        output full, alloc_idx, ckpt_valid, ckpt_write_pointer, ckpt_ds_valid,
        output ckpt_branch_id, ckpt_free_head_pointer, ckpt_rename_buffer
    );

    modport master (
        output alloc_req, alloc_branch_id, alloc_free_head_pointer, alloc_rename_buffer,
        output ds_req, ds_free_head_pointer, ds_rename_buffer,
        output resolve_valid, resolve_branch_id,
        output restore_en, restore_valid, restore_write_pointer,
        input  full, alloc_idx, ckpt_valid, ckpt_write_pointer, ckpt_ds_valid,
        input  ckpt_branch_id, ckpt_free_head_pointer, ckpt_rename_buffer
    );
endinterface

// File: rtl/branch_checkpoint_manager.sv
// Branch checkpoint manager (writer side of the checkpoint state).
// Allocates a circular checkpoint slot per renamed branch capturing its
// active-list id, free-list head and rename map; folds the delay-slot rename
// into the newest slot; frees slots on correct resolution; and reloads
// valid/write pointer from misprediction recovery.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : branch_checkpoint_manager_if.slave (requests in, ckpt_* state out)
// All state is registered; full/alloc_idx are decoded from registers only.
module branch_checkpoint_manager #(
    parameter int BRANCH_NUM             = 4,
    parameter int BRANCH_NUM_INDEX       = 2,
    parameter int REG_NUM                = 32,
    parameter int PHYS_REG_NUM_INDEX     = 6,
    parameter int ACTIVE_LIST_SIZE_INDEX = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    branch_checkpoint_manager_if.slave   bus
);
    localparam int MAP_W = REG_NUM * PHYS_REG_NUM_INDEX;

    logic [BRANCH_NUM-1:0]                                   valid_r;
    logic [BRANCH_NUM-1:0]                                   ds_valid_r;
    logic [BRANCH_NUM_INDEX-1:0]                             wp_r;
    logic [BRANCH_NUM-1:0][ACTIVE_LIST_SIZE_INDEX-1:0]       branch_id_r;
    logic [BRANCH_NUM-1:0][PHYS_REG_NUM_INDEX-1:0]           free_head_r;
    logic [BRANCH_NUM-1:0][MAP_W-1:0]                        rename_r;

    logic [BRANCH_NUM-1:0]                                   valid_n_s;
    logic [BRANCH_NUM-1:0]                                   ds_valid_n_s;
    logic [BRANCH_NUM_INDEX-1:0]                             wp_n_s;
    logic [BRANCH_NUM-1:0]                                   match_s;
    logic [BRANCH_NUM_INDEX-1:0]                             ds_slot_s;
    logic                                                    full_s;
    logic                                                    alloc_fire_s;
    logic                                                    ds_fire_s;

    localparam logic [BRANCH_NUM_INDEX-1:0] WP_ONE = BRANCH_NUM_INDEX'(1);

    // Request qualification; the delay slot always belongs to the slot just
    // behind the pre-edge write pointer, so it never collides with an alloc.
    always_comb begin
        full_s       = valid_r[wp_r];
        ds_slot_s    = wp_r - WP_ONE;
        alloc_fire_s = bus.alloc_req & ~full_s & ~bus.restore_en;
        ds_fire_s    = bus.ds_req & ~bus.restore_en
                       & valid_r[ds_slot_s] & ~ds_valid_r[ds_slot_s];
    end

    // Resolve match vector: every live slot tagged with the resolved id.
    always_comb begin
        match_s = {BRANCH_NUM{1'b0}};
        for (int i = 0; i < BRANCH_NUM; i++) begin
            match_s[i] = valid_r[i] & bus.resolve_valid
                         & (branch_id_r[i] == bus.resolve_branch_id);
        end
    end

    // Next-state for valid, delay-slot valid and write pointer; restore wins.
    always_comb begin
        valid_n_s    = valid_r;
        ds_valid_n_s = ds_valid_r;
        wp_n_s       = wp_r;
        if (bus.restore_en) begin
            valid_n_s    = bus.restore_valid;
            ds_valid_n_s = ds_valid_r & bus.restore_valid;
            wp_n_s       = bus.restore_write_pointer;
        end else begin
            // alloc target is an invalid slot, so it never overlaps a match
            valid_n_s = valid_r & ~match_s;
            if (alloc_fire_s) begin
                valid_n_s[wp_r]    = 1'b1;
                ds_valid_n_s[wp_r] = 1'b0;
                wp_n_s             = wp_r + WP_ONE;
            end else begin
                wp_n_s = wp_r;
            end
            if (ds_fire_s) begin
                ds_valid_n_s[ds_slot_s] = 1'b1;
            end else begin
                ds_valid_n_s[ds_slot_s] = ds_valid_n_s[ds_slot_s];
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r    <= {BRANCH_NUM{1'b0}};
            ds_valid_r <= {BRANCH_NUM{1'b0}};
            wp_r       <= {BRANCH_NUM_INDEX{1'b0}};
        end else begin
            valid_r    <= valid_n_s;
            ds_valid_r <= ds_valid_n_s;
            wp_r       <= wp_n_s;
        end
    end

    // Snapshot payload registers; invalid slots keep stale contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_id_r <= {(BRANCH_NUM*ACTIVE_LIST_SIZE_INDEX){1'b0}};
            free_head_r <= {(BRANCH_NUM*PHYS_REG_NUM_INDEX){1'b0}};
            rename_r    <= {(BRANCH_NUM*MAP_W){1'b0}};
        end else begin
            if (alloc_fire_s) begin
                branch_id_r[wp_r] <= bus.alloc_branch_id;
                free_head_r[wp_r] <= bus.alloc_free_head_pointer;
                rename_r[wp_r]    <= bus.alloc_rename_buffer;
            end
            if (ds_fire_s) begin
                free_head_r[ds_slot_s] <= bus.ds_free_head_pointer;
                rename_r[ds_slot_s]    <= bus.ds_rename_buffer;
            end
        end
    end

    assign bus.full                   = full_s;
    assign bus.alloc_idx              = wp_r;
    assign bus.ckpt_valid             = valid_r;
    assign bus.ckpt_write_pointer     = wp_r;
    assign bus.ckpt_ds_valid          = ds_valid_r;
    assign bus.ckpt_branch_id         = branch_id_r;
    assign bus.ckpt_free_head_pointer = free_head_r;
    assign bus.ckpt_rename_buffer     = rename_r;
endmodule

// File: tb/tb_branch_checkpoint_manager.sv
module tb_branch_checkpoint_manager;
    localparam int BN  = 4;
    localparam int BI  = 2;
    localparam int RN  = 32;
    localparam int PRI = 6;
    localparam int AI  = 5;
    localparam int MW  = RN * PRI;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    branch_checkpoint_manager_if #(
        .BRANCH_NUM(BN), .BRANCH_NUM_INDEX(BI), .REG_NUM(RN),
        .PHYS_REG_NUM_INDEX(PRI), .ACTIVE_LIST_SIZE_INDEX(AI)
    ) bus ();

    branch_checkpoint_manager #(
        .BRANCH_NUM(BN), .BRANCH_NUM_INDEX(BI), .REG_NUM(RN),
        .PHYS_REG_NUM_INDEX(PRI), .ACTIVE_LIST_SIZE_INDEX(AI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Map table pattern: reg r maps to (r + seed) mod 64.
    function automatic logic [MW-1:0] mk_map(input int seed);
        logic [MW-1:0] m;
        m = '0;
        for (int r = 0; r < RN; r++) m[r*PRI +: PRI] = PRI'((r + seed) % 64);
        return m;
    endfunction

    task automatic idle_inputs();
        bus.alloc_req = 1'b0; bus.alloc_branch_id = 5'd0;
        bus.alloc_free_head_pointer = 6'd0; bus.alloc_rename_buffer = '0;
        bus.ds_req = 1'b0; bus.ds_free_head_pointer = 6'd0; bus.ds_rename_buffer = '0;
        bus.resolve_valid = 1'b0; bus.resolve_branch_id = 5'd0;
        bus.restore_en = 1'b0; bus.restore_valid = 4'd0; bus.restore_write_pointer = 2'd0;
    endtask

    // Advance one edge, then settle before sampling and redriving inputs.
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_alloc(input logic [4:0] id, input logic [5:0] fh, input int seed);
        bus.alloc_req = 1'b1; bus.alloc_branch_id = id;
        bus.alloc_free_head_pointer = fh; bus.alloc_rename_buffer = mk_map(seed);
        step();
    endtask

    task automatic do_ds(input logic [5:0] fh, input int seed);
        bus.ds_req = 1'b1; bus.ds_free_head_pointer = fh; bus.ds_rename_buffer = mk_map(seed);
        step();
    endtask

    task automatic do_resolve(input logic [4:0] id);
        bus.resolve_valid = 1'b1; bus.resolve_branch_id = id;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.ckpt_valid !== 4'b0000 || bus.ckpt_write_pointer !== 2'd0 || bus.ckpt_ds_valid !== 4'b0000) begin
            $display("FAIL reset_ctrl valid=%b wp=%0d ds=%b required 0000/0/0000", bus.ckpt_valid, bus.ckpt_write_pointer, bus.ckpt_ds_valid);
        end else pass_cnt++;
        total_cnt++;
        if (bus.full !== 1'b0 || bus.alloc_idx !== 2'd0) begin
            $display("FAIL reset_full full=%b idx=%0d required 0/0", bus.full, bus.alloc_idx);
        end else pass_cnt++;
        total_cnt++;
        if (bus.ckpt_branch_id !== 20'd0 || bus.ckpt_free_head_pointer !== 24'd0 || bus.ckpt_rename_buffer !== '0) begin
            $display("FAIL reset_payload id=%h fh=%h required 0", bus.ckpt_branch_id, bus.ckpt_free_head_pointer);
        end else pass_cnt++;
    endtask

    // Slot 0 id 3, slot 1 id 7 (fh 5), then delay slot folds into slot 1.
    task automatic test_delay_slot();
        do_alloc(5'd3, 6'd1, 1);
        do_alloc(5'd7, 6'd5, 2);
        total_cnt++;
        if (bus.ckpt_free_head_pointer[1*PRI +: PRI] !== 6'd5 || bus.ckpt_ds_valid !== 4'b0000) begin
            $display("FAIL ds_pre fh1=%0d ds=%b required 5/0000", bus.ckpt_free_head_pointer[1*PRI +: PRI], bus.ckpt_ds_valid);
        end else pass_cnt++;
        do_ds(6'd9, 20);
        total_cnt++;
        if (bus.ckpt_ds_valid !== 4'b0010 || bus.ckpt_free_head_pointer[1*PRI +: PRI] !== 6'd9) begin
            $display("FAIL ds_update ds=%b fh1=%0d required 0010/9", bus.ckpt_ds_valid, bus.ckpt_free_head_pointer[1*PRI +: PRI]);
        end else pass_cnt++;
        total_cnt++;
        if (bus.ckpt_rename_buffer[1*MW +: MW] !== mk_map(20) || bus.ckpt_rename_buffer[0 +: MW] !== mk_map(1)) begin
            $display("FAIL ds_map slot1=%h slot0=%h", bus.ckpt_rename_buffer[1*MW +: 24], bus.ckpt_rename_buffer[0 +: 24]);
        end else pass_cnt++;
        do_ds(6'd13, 30);
        total_cnt++;
        if (bus.ckpt_free_head_pointer[1*PRI +: PRI] !== 6'd9 || bus.ckpt_rename_buffer[1*MW +: MW] !== mk_map(20)) begin
            $display("FAIL ds_second fh1=%0d required 9", bus.ckpt_free_head_pointer[1*PRI +: PRI]);
        end else pass_cnt++;
    endtask

    // Fill remaining slots (ids 12, 20), wrap, then a dropped 5th alloc.
    task automatic test_fill_and_full();
        do_alloc(5'd12, 6'd10, 3);
        do_alloc(5'd20, 6'd11, 4);
        total_cnt++;
        if (bus.ckpt_valid !== 4'b1111 || bus.ckpt_write_pointer !== 2'd0 || bus.full !== 1'b1) begin
            $display("FAIL fill valid=%b wp=%0d full=%b required 1111/0/1", bus.ckpt_valid, bus.ckpt_write_pointer, bus.full);
        end else pass_cnt++;
        total_cnt++;
        if (bus.ckpt_branch_id !== {5'd20, 5'd12, 5'd7, 5'd3}) begin
            $display("FAIL fill_ids got=%h required %h", bus.ckpt_branch_id, {5'd20, 5'd12, 5'd7, 5'd3});
        end else pass_cnt++;
        do_alloc(5'd25, 6'd40, 9);
        total_cnt++;
        if (bus.ckpt_branch_id[4:0] !== 5'd3 || bus.ckpt_write_pointer !== 2'd0 || bus.ckpt_valid !== 4'b1111
            || bus.ckpt_free_head_pointer[5:0] !== 6'd1) begin
            $display("FAIL full_drop id0=%0d wp=%0d valid=%b required 3/0/1111", bus.ckpt_branch_id[4:0], bus.ckpt_write_pointer, bus.ckpt_valid);
        end else pass_cnt++;
    endtask

    task automatic test_resolve_reuse();
        do_resolve(5'd3);
        total_cnt++;
        if (bus.ckpt_valid !== 4'b1110 || bus.full !== 1'b0 || bus.alloc_idx !== 2'd0) begin
            $display("FAIL resolve valid=%b full=%b idx=%0d required 1110/0/0", bus.ckpt_valid, bus.full, bus.alloc_idx);
        end else pass_cnt++;
        do_alloc(5'd30, 6'd15, 5);
        total_cnt++;
        if (bus.ckpt_branch_id[4:0] !== 5'd30 || bus.ckpt_write_pointer !== 2'd1 || bus.ckpt_valid !== 4'b1111
            || bus.full !== 1'b1) begin
            $display("FAIL reuse id0=%0d wp=%0d valid=%b full=%b required 30/1/1111/1", bus.ckpt_branch_id[4:0], bus.ckpt_write_pointer, bus.ckpt_valid, bus.full);
        end else pass_cnt++;
    endtask

    task automatic test_resolve_nomatch();
        do_resolve(5'd15);
        total_cnt++;
        if (bus.ckpt_valid !== 4'b1111 || bus.ckpt_write_pointer !== 2'd1 || bus.ckpt_ds_valid !== 4'b0010) begin
            $display("FAIL nomatch valid=%b wp=%0d ds=%b required 1111/1/0010", bus.ckpt_valid, bus.ckpt_write_pointer, bus.ckpt_ds_valid);
        end else pass_cnt++;
    endtask

    // Alloc, delay slot and resolve in one cycle all apply.
    task automatic test_back_to_back();
        do_resolve(5'd7);
        total_cnt++;
        if (bus.ckpt_valid !== 4'b1101 || bus.full !== 1'b0) begin
            $display("FAIL b2b_free valid=%b full=%b required 1101/0", bus.ckpt_valid, bus.full);
        end else pass_cnt++;
        bus.alloc_req = 1'b1; bus.alloc_branch_id = 5'd9;
        bus.alloc_free_head_pointer = 6'd17; bus.alloc_rename_buffer = mk_map(6);
        bus.ds_req = 1'b1; bus.ds_free_head_pointer = 6'd21; bus.ds_rename_buffer = mk_map(7);
        bus.resolve_valid = 1'b1; bus.resolve_branch_id = 5'd12;
        step();
        total_cnt++;
        if (bus.ckpt_valid !== 4'b1011 || bus.ckpt_write_pointer !== 2'd2 || bus.ckpt_ds_valid !== 4'b0001 || bus.full !== 1'b0) begin
            $display("FAIL b2b_ctrl valid=%b wp=%0d ds=%b full=%b required 1011/2/0001/0", bus.ckpt_valid, bus.ckpt_write_pointer, bus.ckpt_ds_valid, bus.full);
        end else pass_cnt++;
        total_cnt++;
        if (bus.ckpt_branch_id[5 +: 5] !== 5'd9 || bus.ckpt_free_head_pointer[6 +: 6] !== 6'd17
            || bus.ckpt_free_head_pointer[0 +: 6] !== 6'd21 || bus.ckpt_rename_buffer[0 +: MW] !== mk_map(7)) begin
            $display("FAIL b2b_payload id1=%0d fh1=%0d fh0=%0d required 9/17/21", bus.ckpt_branch_id[5 +: 5], bus.ckpt_free_head_pointer[6 +: 6], bus.ckpt_free_head_pointer[0 +: 6]);
        end else pass_cnt++;
    endtask

    task automatic test_restore();
        do_alloc(5'd22, 6'd25, 8);
        do_ds(6'd27, 10);
        do_resolve(5'd20);
        total_cnt++;
        if (bus.ckpt_valid !== 4'b0111 || bus.ckpt_write_pointer !== 2'd3 || bus.ckpt_ds_valid !== 4'b0101) begin
            $display("FAIL restore_pre valid=%b wp=%0d ds=%b required 0111/3/0101", bus.ckpt_valid, bus.ckpt_write_pointer, bus.ckpt_ds_valid);
        end else pass_cnt++;
        bus.restore_en = 1'b1; bus.restore_valid = 4'b0001; bus.restore_write_pointer = 2'd1;
        bus.alloc_req = 1'b1; bus.alloc_branch_id = 5'd31;
        bus.alloc_free_head_pointer = 6'd33; bus.alloc_rename_buffer = mk_map(11);
        bus.ds_req = 1'b1; bus.ds_free_head_pointer = 6'd40; bus.ds_rename_buffer = mk_map(12);
        bus.resolve_valid = 1'b1; bus.resolve_branch_id = 5'd30;
        step();
        total_cnt++;
        if (bus.ckpt_valid !== 4'b0001 || bus.ckpt_write_pointer !== 2'd1 || bus.ckpt_ds_valid !== 4'b0001 || bus.full !== 1'b0) begin
            $display("FAIL restore_ctrl valid=%b wp=%0d ds=%b full=%b required 0001/1/0001/0", bus.ckpt_valid, bus.ckpt_write_pointer, bus.ckpt_ds_valid, bus.full);
        end else pass_cnt++;
        total_cnt++;
        if (bus.ckpt_branch_id !== {5'd20, 5'd22, 5'd9, 5'd30} || bus.ckpt_free_head_pointer[12 +: 6] !== 6'd27
            || bus.ckpt_free_head_pointer[18 +: 6] !== 6'd11) begin
            $display("FAIL restore_payload ids=%h fh=%h", bus.ckpt_branch_id, bus.ckpt_free_head_pointer);
        end else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        do_alloc(5'd4, 6'd2, 13);
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.ckpt_valid !== 4'b0000 || bus.ckpt_write_pointer !== 2'd0 || bus.ckpt_ds_valid !== 4'b0000
            || bus.full !== 1'b0 || bus.ckpt_branch_id !== 20'd0) begin
            $display("FAIL mid_reset valid=%b wp=%0d ds=%b full=%b required 0000/0/0000/0", bus.ckpt_valid, bus.ckpt_write_pointer, bus.ckpt_ds_valid, bus.full);
        end else pass_cnt++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_delay_slot();
        test_fill_and_full();
        test_resolve_reuse();
        test_resolve_nomatch();
        test_back_to_back();
        test_restore();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
